// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one operation at a time, single-port request/ack memory,
// raw right-justified load data handed to the downstream extension stage.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif
`ifndef AWIDTH
`define AWIDTH 32
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                     ma_clk,
    input  logic                     ma_rst,
    input  logic                     ma_i_valid,
    output logic                     ma_o_ready,
    input  logic [`OPCODE_WIDTH-1:0] ma_i_opcode,
    input  logic [`AWIDTH-1:0]       ma_i_addr,
    input  logic [`DWIDTH-1:0]       ma_i_wdata,
    input  logic [4:0]               ma_i_rd,
    output logic                     mem_o_req,
    output logic                     mem_o_we,
    output logic [`AWIDTH-1:0]       mem_o_addr,
    output logic [3:0]               mem_o_be,
    output logic [`DWIDTH-1:0]       mem_o_wdata,
    input  logic                     mem_i_ack,
    input  logic [`DWIDTH-1:0]       mem_i_rdata,
    output logic                     ma_o_valid,
    input  logic                     ma_i_ready,
    output logic [`DWIDTH-1:0]       ma_o_load_data,
    output logic [`OPCODE_WIDTH-1:0] ma_o_opcode,
    output logic [4:0]               ma_o_rd,
    output logic                     ma_o_misalign,
    output logic                     ma_o_timeout
);

    localparam logic [`OPCODE_WIDTH-1:0] OP_LB  = `OPCODE_WIDTH'(1);
    localparam logic [`OPCODE_WIDTH-1:0] OP_LH  = `OPCODE_WIDTH'(2);
    localparam logic [`OPCODE_WIDTH-1:0] OP_LW  = `OPCODE_WIDTH'(3);
    localparam logic [`OPCODE_WIDTH-1:0] OP_LBU = `OPCODE_WIDTH'(4);
    localparam logic [`OPCODE_WIDTH-1:0] OP_LHU = `OPCODE_WIDTH'(5);
    localparam logic [`OPCODE_WIDTH-1:0] OP_SB  = `OPCODE_WIDTH'(8);
    localparam logic [`OPCODE_WIDTH-1:0] OP_SH  = `OPCODE_WIDTH'(9);
    localparam logic [`OPCODE_WIDTH-1:0] OP_SW  = `OPCODE_WIDTH'(10);
    localparam logic [CNT_WIDTH-1:0]     CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                     r_state, w_state_nxt;
    logic                       r_req, w_req_nxt;
    logic                       r_we, w_we_nxt;
    logic [3:0]                 r_be, w_be_nxt;
    logic [`AWIDTH-1:0]         r_addr, w_addr_nxt;
    logic [`DWIDTH-1:0]         r_wdata, w_wdata_nxt;
    logic [CNT_WIDTH-1:0]       r_cnt, w_cnt_nxt;
    logic [1:0]                 r_lane, w_lane_nxt;
    logic [`OPCODE_WIDTH-1:0]   r_op, w_op_nxt;
    logic [4:0]                 r_rd, w_rd_nxt;
    logic                       r_valid, w_valid_nxt;
    logic [`DWIDTH-1:0]         r_data, w_data_nxt;
    logic [4:0]                 r_rd_out, w_rd_out_nxt;
    logic                       r_misalign, w_misalign_nxt;
    logic                       r_timeout, w_timeout_nxt;
    logic                       w_misal_in;

    function automatic logic isLoad(input logic [`OPCODE_WIDTH-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic isStore(input logic [`OPCODE_WIDTH-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    assign w_misal_in = (((ma_i_opcode == OP_LH) || (ma_i_opcode == OP_LHU) || (ma_i_opcode == OP_SH)) && ma_i_addr[0])
                     || (((ma_i_opcode == OP_LW) || (ma_i_opcode == OP_SW)) && (ma_i_addr[1:0] != 2'b00));

    // Next-state and next-register values; every register holds unless a branch overrides it.
    always_comb begin
        w_state_nxt    = r_state;
        w_req_nxt      = r_req;
        w_we_nxt       = r_we;
        w_be_nxt       = r_be;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_cnt_nxt      = r_cnt;
        w_lane_nxt     = r_lane;
        w_op_nxt       = r_op;
        w_rd_nxt       = r_rd;
        w_valid_nxt    = r_valid;
        w_data_nxt     = r_data;
        w_rd_out_nxt   = r_rd_out;
        w_misalign_nxt = r_misalign;
        w_timeout_nxt  = r_timeout;
        case (r_state)
            IDLE: begin
                if (ma_i_valid) begin
                    w_op_nxt   = ma_i_opcode;
                    w_rd_nxt   = ma_i_rd;
                    w_lane_nxt = ma_i_addr[1:0];
                    if (!isLoad(ma_i_opcode) && !isStore(ma_i_opcode)) begin
                        w_state_nxt    = RESP;
                        w_valid_nxt    = 1'b1;
                        w_data_nxt     = '0;
                        w_rd_out_nxt   = '0;
                        w_misalign_nxt = 1'b0;
                        w_timeout_nxt  = 1'b0;
                    end else if (w_misal_in) begin
                        w_state_nxt    = RESP;
                        w_valid_nxt    = 1'b1;
                        w_data_nxt     = '0;
                        w_rd_out_nxt   = isLoad(ma_i_opcode) ? ma_i_rd : 5'd0;
                        w_misalign_nxt = 1'b1;
                        w_timeout_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = REQ;
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = isStore(ma_i_opcode);
                        w_addr_nxt  = {ma_i_addr[`AWIDTH-1:2], 2'b00};
                        w_cnt_nxt   = '0;
                        case (ma_i_opcode)
                            OP_SB: begin
                                w_be_nxt    = 4'b0001 << ma_i_addr[1:0];
                                w_wdata_nxt = {4{ma_i_wdata[7:0]}};
                            end
                            OP_SH: begin
                                w_be_nxt    = 4'b0011 << ma_i_addr[1:0];
                                w_wdata_nxt = {2{ma_i_wdata[15:0]}};
                            end
                            OP_SW: begin
                                w_be_nxt    = 4'b1111;
                                w_wdata_nxt = ma_i_wdata;
                            end
                            default: begin
                                w_be_nxt    = 4'b1111;
                                w_wdata_nxt = '0;
                            end
                        endcase
                    end
                end
            end
            REQ: begin
                if (mem_i_ack || (r_cnt == CNT_LAST)) begin
                    w_state_nxt    = RESP;
                    w_req_nxt      = 1'b0;
                    w_we_nxt       = 1'b0;
                    w_be_nxt       = 4'b0000;
                    w_addr_nxt     = '0;
                    w_wdata_nxt    = '0;
                    w_cnt_nxt      = '0;
                    w_valid_nxt    = 1'b1;
                    w_rd_out_nxt   = isLoad(r_op) ? r_rd : 5'd0;
                    w_misalign_nxt = 1'b0;
                    // An ack on the final allowed cycle still completes normally.
                    w_timeout_nxt  = !mem_i_ack;
                    w_data_nxt     = (mem_i_ack && isLoad(r_op)) ? (mem_i_rdata >> {r_lane, 3'b000}) : '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RESP: begin
                if (ma_i_ready) begin
                    w_state_nxt = IDLE;
                    w_valid_nxt = 1'b0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Every output is registered; reset clears them immediately, dropping any in-flight request.
    always_ff @(posedge ma_clk or negedge ma_rst) begin
        if (!ma_rst) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_be       <= 4'b0000;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_lane     <= 2'b00;
            r_op       <= '0;
            r_rd       <= '0;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_rd_out   <= '0;
            r_misalign <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_req      <= w_req_nxt;
            r_we       <= w_we_nxt;
            r_be       <= w_be_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_cnt      <= w_cnt_nxt;
            r_lane     <= w_lane_nxt;
            r_op       <= w_op_nxt;
            r_rd       <= w_rd_nxt;
            r_valid    <= w_valid_nxt;
            r_data     <= w_data_nxt;
            r_rd_out   <= w_rd_out_nxt;
            r_misalign <= w_misalign_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign ma_o_ready     = (r_state == IDLE);
    assign mem_o_req      = r_req;
    assign mem_o_we       = r_we;
    assign mem_o_be       = r_be;
    assign mem_o_addr     = r_addr;
    assign mem_o_wdata    = r_wdata;
    assign ma_o_valid     = r_valid;
    assign ma_o_load_data = r_data;
    assign ma_o_opcode    = r_op;
    assign ma_o_rd        = r_rd_out;
    assign ma_o_misalign  = r_misalign;
    assign ma_o_timeout   = r_timeout;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store engine that sits directly upstream of the load-extension stage.
- Accepts one memory operation at a time from execute and drives a single-port data-memory request/acknowledge interface.
- For loads, it shifts the selected byte/half into bit 0 and presents the raw, unextended word plus opcode to the extension stage. Sign or zero extension is done downstream.
- For stores, it generates byte enables and lane-replicated write data. It detects misalignment and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles waiting for mem_ack before aborting with an error.
- CNT_WIDTH, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- ma_clk  input  1  clock; all state changes on the rising edge.
- ma_rst  input  1  asynchronous, active-low reset.
- ma_i_valid  input  1  execute presents an operation.
- ma_o_ready  output  1  unit can accept an operation (high only in IDLE).
- ma_i_opcode  input  `OPCODE_WIDTH  LOAD_BYTE/…/LOAD_WORD, STORE_BYTE/STORE_HALF/STORE_WORD.
- ma_i_addr  input  `AWIDTH  byte address.
- ma_i_wdata  input  `DWIDTH  store data, right-justified.
- ma_i_rd  input  5  load destination register.
- mem_o_req  output  1  memory request.
- mem_o_we  output  1  write enable.
- mem_o_addr  output  `AWIDTH  word-aligned address (addr[1:0]=0).
- mem_o_be  output  4  byte enables.
- mem_o_wdata  output  `DWIDTH  lane-positioned write data.
- mem_i_ack  input  1  memory completes the access (read data valid the same cycle).
- mem_i_rdata  input  `DWIDTH  read word.
- ma_o_valid  output  1  result valid to the extension/writeback stage.
- ma_i_ready  input  1  downstream accepts the result.
- ma_o_load_data  output  `DWIDTH  read word shifted right by 8*addr[1:0]; 0 for stores and errors.
- ma_o_opcode  output  `OPCODE_WIDTH  opcode of the completed operation.
- ma_o_rd  output  5  destination register; 0 for stores.
- ma_o_misalign  output  1  address misaligned for the access size.
- ma_o_timeout  output  1  memory did not acknowledge within TIMEOUT_CYCLES.

Behaviour:
- Reset (ma_rst=0, async): state IDLE; mem_o_req=0, mem_o_we=0, mem_o_be=0, mem_o_addr=0, mem_o_wdata=0; ma_o_valid=0, ma_o_load_data=0, ma_o_opcode=0, ma_o_rd=0, flags=0; counter=0.
- Reset mid-transaction drops mem_o_req immediately. An in-flight ack is ignored after reset.
- FSM states: IDLE, REQ, RESP.
- IDLE: ma_o_ready=1. Accept when ma_i_valid=1 and latch opcode, addr, wdata and rd.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0): go to RESP with misalign=1. No memory request is issued.
  - Opcode not a load or store: RESP with all flags 0, load_data=0, rd=0. Acts as a no-op pass-through.
  - Otherwise go to REQ.
- REQ: mem_o_req=1 held stable until ack.
  - mem_o_addr = {addr[AWIDTH-1:2],2'b00}.
  - Loads: we=0, be=4'b1111.
  - Stores: we=1.
    - Byte: be=1<<addr[1:0], wdata={4{wdata[7:0]}}.
    - Half: be=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}.
    - Word: be=4'b1111, wdata unchanged.
  - Counter increments each REQ cycle without ack.
  - Ack: capture (mem_i_rdata >> 8*addr[1:0]) for loads, 0 for stores. Drop req the next cycle, go to RESP.
  - Counter reaching TIMEOUT_CYCLES without ack: drop req, go to RESP with timeout=1.
  - Ack and timeout in the same cycle: ack wins.
- RESP: ma_o_valid=1, outputs registered and stable until ma_i_ready=1; then return to IDLE with valid=0.
  - No new operation is accepted in RESP (ready=0), so there is no bypass.
  - Min latency, load with 0-wait memory: accept cycle N, req in N+1, ack in N+1, valid in N+2.
  - Misaligned access: valid at N+1.

Test Plan:
- LOAD_BYTE at addr 0x103, memory returns 0x80AABBCC with ack after 2 wait cycles -> req held 3 cycles; mem_o_addr=0x100; ma_o_load_data=0x00000080; valid until ma_i_ready.
- STORE_HALF at 0x202 with wdata 0x1234ABCD, immediate ack -> mem_o_we=1, mem_o_be=4'b1100, mem_o_wdata=0xABCDABCD, addr 0x200; response load_data=0, rd=0.
- LOAD_WORD at 0x301 -> no mem_o_req ever; ma_o_misalign=1 and valid one cycle after accept.
- LOAD_HALF with no ack, TIMEOUT_CYCLES=16 -> req deasserts after 16 cycles; ma_o_timeout=1.
- Back-to-back loads with ma_i_ready held low 5 cycles -> ma_o_ready=0 throughout; first result stable; second accepted only after ready returns to IDLE.
- Assert ma_rst low while in REQ -> all outputs 0 asynchronously, FSM back in IDLE; a late ack causes no response.
